// File: rtl/sprite_blit_source.sv
// Sprite BRAM reader feeding the framebuffer burst writer: row-major fetch, 2-deep prefetch,
// colour-key draw flag. Define SPRITE_FLIP_H_EN to add per-blit horizontal mirroring (flip_h).
module sprite_blit_source #(
  parameter int unsigned MEM_ADDR_W = 14,
  parameter logic [7:0]  COLORKEY   = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] src_base,
  input  logic [10:0]           dst_x,
  input  logic [10:0]           dst_y,
  input  logic [10:0]           blit_w,
  input  logic [10:0]           blit_h,
`ifdef SPRITE_FLIP_H_EN
  input  logic                  flip_h,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [10:0]           pixel_x,
  output logic [10:0]           pixel_y,
  output logic [10:0]           width,
  output logic [10:0]           height,
  output logic [7:0]            pixel_data,
  output logic                  pixel_valid,
  output logic                  draw,
  input  logic                  pixel_ready
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                state_q, state_d;
  logic [10:0]           col_q, col_d, row_q, row_d;
  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [10:0]           x_q, y_q, w_q, h_q;
  logic [7:0]            fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, done_q, done_d;

  logic                  start_go, push, pop, fetching, last, cur_flip;
  logic [10:0]           cur_col, cur_row, cur_w, cur_h, offset;
  logic [MEM_ADDR_W-1:0] cur_base;
  logic [2:0]            credit;

  assign start_go = (state_q == StIdle) && start;

`ifdef SPRITE_FLIP_H_EN
  logic flip_q;
  assign cur_flip = start_go ? flip_h : flip_q;
  always_ff @(posedge clk) begin
    if (reset)         flip_q <= 1'b0;
    else if (start_go) flip_q <= flip_h;
  end
`else
  assign cur_flip = 1'b0;
`endif

  // The start cycle issues the first read straight from the inputs so data lands 2 cycles later.
  always_comb begin
    cur_col  = col_q;
    cur_row  = row_q;
    cur_base = base_q;
    cur_w    = w_q;
    cur_h    = h_q;
    if (start_go) begin
      cur_col  = '0;
      cur_row  = '0;
      cur_base = src_base;
      cur_w    = blit_w;
      cur_h    = blit_h;
    end
  end

  assign push     = inflight_q;
  assign pop      = pixel_valid && pixel_ready;
  // A same-cycle pop frees a slot, which keeps the stream at one pixel per cycle.
  assign credit   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign fetching = start_go || (state_q == StFetch);
  assign last     = (cur_col == cur_w) && (cur_row == cur_h);
  assign offset   = cur_flip ? (cur_w - cur_col) : cur_col;

  assign mem_rd_en = !reset && fetching && (credit < 3'd2);
  assign mem_addr  = mem_rd_en ? (cur_base + MEM_ADDR_W'(offset)) : '0;

  always_comb begin
    col_d  = cur_col;
    row_d  = cur_row;
    base_d = cur_base;
    if (mem_rd_en) begin
      if (cur_col == cur_w) begin
        col_d  = '0;
        row_d  = cur_row + 11'd1;
        base_d = cur_base + MEM_ADDR_W'(cur_w) + MEM_ADDR_W'(1);
      end else begin
        col_d  = cur_col + 11'd1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_go) state_d = (mem_rd_en && last) ? StDrain : StFetch;
      end
      StFetch: begin
        if (mem_rd_en && last) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_d == 2'd0 && !mem_rd_en) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      inflight_q <= mem_rd_en;
      done_q     <= done_d;
      if (start_go) begin
        x_q <= dst_x;
        y_q <= dst_y;
        w_q <= blit_w;
        h_q <= blit_h;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign width       = w_q;
  assign height      = h_q;
  assign pixel_valid = (cnt_q != 2'd0);
  assign pixel_data  = fifo_q[rd_ptr_q];
  assign draw        = pixel_valid && (pixel_data != COLORKEY);

endmodule
